serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/full_adder_cell.sv | 20 ++
 rtl/serial_adder.sv | 132 +++++++++++++
 tb/tb_serial_adder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// FSM state encoding and the default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half-adder stages and an OR for the carry.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic hs1_sum_s;
  logic hs1_carry_s;
  logic hs2_carry_s;

  assign hs1_sum_s   = x ^ y;
  assign hs1_carry_s = x & y;
  assign s           = hs1_sum_s ^ ci;
  assign hs2_carry_s = hs1_sum_s & ci;
  assign co          = hs1_carry_s | hs2_carry_s;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder with valid/ready handshakes on both sides.
// Adds one bit per cycle through a single full-adder cell, LSB first.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;

  logic             fa_sum_s;
  logic             fa_carry_s;
  logic             accept_s;
  logic             release_s;
  logic             last_s;
  logic [WIDTH-1:0] a_shift_s;
  logic [WIDTH-1:0] b_shift_s;
  logic [WIDTH-1:0] res_shift_s;

  full_adder_cell u_fa (
    .x  (a_r[0]),
    .y  (b_r[0]),
    .ci (carry_r),
    .s  (fa_sum_s),
    .co (fa_carry_s)
  );

  // Handshake decode, shift datapath and next-state selection.
  always_comb begin
    accept_s    = in_valid & in_ready;
    release_s   = out_valid & out_ready;
    last_s      = (cnt_r == CW'(WIDTH - 1));
    a_shift_s   = a_r >> 1;
    b_shift_s   = b_r >> 1;
    res_shift_s = res_r >> 1;
    res_shift_s[WIDTH-1] = fa_sum_s;
    state_s     = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = ADD;
        end else begin
          state_s = IDLE;
        end
      end
      ADD: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = ADD;
        end
      end
      DONE: begin
        if (release_s) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      res_r     <= '0;
      carry_r   <= 1'b0;
      cnt_r     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r <= state_s;
      // in_ready and out_valid lag state entry by one cycle, which gives
      // the idle gap after a result is taken and the extra latency cycle.
      in_ready  <= (state_r == IDLE) && !accept_s;
      out_valid <= (state_r == DONE) && !release_s;
      busy      <= (state_s == ADD);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            cnt_r   <= '0;
          end
        end
        ADD: begin
          a_r     <= a_shift_s;
          b_r     <= b_shift_s;
          res_r   <= res_shift_s;
          carry_r <= fa_carry_s;
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            sum  <= res_shift_s;
            cout <= fa_carry_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 instances against a cycle-timed
// arithmetic model, plus directed vectors with hand-computed results.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       iv   [2];
  logic       ordy [2];
  logic [7:0] av   [2];
  logic [7:0] bv   [2];
  logic       ci   [2];
  logic       ir   [2];
  logic       ov   [2];
  logic       co   [2];
  logic       bz   [2];
  logic [7:0] sv8;
  logic       sv1;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  bit armed    = 1'b0;

  bit         pend  [2];
  int         acc_e [2];
  int         rel_e [2];
  logic [7:0] es    [2];
  logic       ec    [2];
  logic [7:0] ls    [2];
  logic       lc    [2];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(av[0]), .b(bv[0]), .cin(ci[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .sum(sv8), .cout(co[0]), .busy(bz[0])
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(av[1][0:0]), .b(bv[1][0:0]), .cin(ci[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .sum(sv1), .cout(co[1]), .busy(bz[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // Model: result = (a+b+cin) captured at the accept edge; ADD occupies WIDTH
  // cycles, out_valid follows one cycle later, in_ready returns one cycle
  // after the result is taken.
  always @(negedge clk) begin
    int         w;
    int         e;
    logic       ir_e, ov_e, bz_e, c_e;
    logic [7:0] s_e, s_act, mask;
    logic [8:0] full;
    e = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      w    = (d == 0) ? 8 : 1;
      mask = (d == 0) ? 8'hFF : 8'h01;
      ir_e = !pend[d] && (cyc >= rel_e[d] + 1);
      bz_e = pend[d] && (cyc < acc_e[d] + w);
      ov_e = pend[d] && (cyc >= acc_e[d] + w + 1);
      if (pend[d] && (cyc >= acc_e[d] + w)) begin
        s_e = es[d];
        c_e = ec[d];
      end else begin
        s_e = ls[d];
        c_e = lc[d];
      end
      s_act = (d == 0) ? sv8 : {7'b0000000, sv1};
      if (armed) begin
        chk($sformatf("in_ready_w%0d", w), {31'd0, ir[d]}, {31'd0, ir_e});
        chk($sformatf("out_valid_w%0d", w), {31'd0, ov[d]}, {31'd0, ov_e});
        chk($sformatf("busy_w%0d", w), {31'd0, bz[d]}, {31'd0, bz_e});
        chk($sformatf("sum_w%0d", w), {24'd0, s_act}, {24'd0, s_e});
        chk($sformatf("cout_w%0d", w), {31'd0, co[d]}, {31'd0, c_e});
      end
      if (rst) begin
        pend[d]  = 1'b0;
        rel_e[d] = e - 1;
        ls[d]    = 8'h00;
        lc[d]    = 1'b0;
      end else begin
        if (ov_e && ordy[d]) begin
          pend[d]  = 1'b0;
          rel_e[d] = e;
          ls[d]    = es[d];
          lc[d]    = ec[d];
        end
        if (ir_e && iv[d]) begin
          full     = {1'b0, av[d] & mask} + {1'b0, bv[d] & mask} + {8'd0, ci[d]};
          pend[d]  = 1'b1;
          acc_e[d] = e;
          es[d]    = full[7:0] & mask;
          ec[d]    = (d == 0) ? full[8] : full[1];
        end
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic accept8(input logic [7:0] a_i, input logic [7:0] b_i, input logic c_i,
                         input string nm);
    int   n;
    logic hs;
    av[0] = a_i; bv[0] = b_i; ci[0] = c_i; iv[0] = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < 100) begin
      hs = ir[0];
      @(posedge clk); #1;
      n++;
    end
    iv[0] = 1'b0; av[0] = ~a_i; bv[0] = 8'h5A; ci[0] = ~c_i;
    chk({nm, "_accepted"}, {31'd0, hs}, 32'd1);
  endtask

  task automatic wait_valid8(input string nm, output int lat);
    lat = 0;
    while (!ov[0] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_valid_seen"}, {31'd0, ov[0]}, 32'd1);
  endtask

  task automatic op8(input logic [7:0] a_i, input logic [7:0] b_i, input logic c_i,
                     input logic [7:0] s_i, input logic c_o, input string nm);
    int lat;
    accept8(a_i, b_i, c_i, nm);
    wait_valid8(nm, lat);
    chk({nm, "_latency"}, lat, 32'd9);
    chk({nm, "_sum"}, {24'd0, sv8}, {24'd0, s_i});
    chk({nm, "_cout"}, {31'd0, co[0]}, {31'd0, c_o});
  endtask

  task automatic release8();
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
  endtask

  task automatic rand_run(input int d);
    int   ops;
    int   n;
    logic hs;
    ops = 0; n = 0;
    while (ops < 1000 && n < 60000) begin
      iv[d]   = ($urandom_range(0, 3) != 0);
      av[d]   = 8'($urandom);
      bv[d]   = 8'($urandom);
      ci[d]   = 1'($urandom);
      ordy[d] = 1'($urandom);
      hs = iv[d] && ir[d];
      @(posedge clk); #1;
      if (hs) ops++;
      n++;
    end
    iv[d] = 1'b0; ordy[d] = 1'b1;
    chk($sformatf("random_ops_d%0d", d), ops, 32'd1000);
  endtask

  initial begin
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic       tc [3];
    logic [7:0] ts [3];
    logic       tco[3];
    int         lat;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; av[d] = 8'h00; bv[d] = 8'h00; ci[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", {31'd0, ir[0]}, 32'd1);
    chk("reset_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("reset_sum", {24'd0, sv8}, 32'd0);

    op8(8'h3C, 8'h55, 1'b0, 8'h91, 1'b0, "add_3c_55");
    for (int k = 0; k < 5; k++) begin
      iv[0] = 1'b1; av[0] = 8'hAA; bv[0] = 8'h11;
      @(posedge clk); #1;
      chk("bp_sum_stable", {24'd0, sv8}, 32'h91);
      chk("bp_in_ready_low", {31'd0, ir[0]}, 32'd0);
      chk("bp_out_valid_held", {31'd0, ov[0]}, 32'd1);
    end
    iv[0] = 1'b0;
    release8();
    repeat (3) @(posedge clk);
    #1;
    chk("idle_sum_held", {24'd0, sv8}, 32'h91);
    chk("idle_not_busy", {31'd0, bz[0]}, 32'd0);

    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
    release8();
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");
    release8();

    accept8(8'h12, 8'h34, 1'b0, "abort_op");
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", {31'd0, ir[0]}, 32'd1);
    chk("abort_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("abort_busy", {31'd0, bz[0]}, 32'd0);
    chk("abort_sum", {24'd0, sv8}, 32'd0);
    chk("abort_cout", {31'd0, co[0]}, 32'd0);
    op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "add_01_01");
    release8();

    ta = '{8'h10, 8'h80, 8'h7F}; tb = '{8'h20, 8'h80, 8'h01}; tc = '{1'b0, 1'b0, 1'b1};
    ts = '{8'h30, 8'h00, 8'h81}; tco = '{1'b0, 1'b1, 1'b0};
    ordy[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int   n;
      logic hs;
      av[0] = ta[k]; bv[0] = tb[k]; ci[0] = tc[k]; iv[0] = 1'b1;
      n = 0; hs = 1'b0;
      while (!hs && n < 100) begin
        hs = ir[0];
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("b2b_accept_%0d", k), {31'd0, hs}, 32'd1);
      wait_valid8($sformatf("b2b_%0d", k), lat);
      chk($sformatf("b2b_sum_%0d", k), {24'd0, sv8}, {24'd0, ts[k]});
      chk($sformatf("b2b_cout_%0d", k), {31'd0, co[0]}, {31'd0, tco[k]});
      if (k == 2) iv[0] = 1'b0;
    end
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    fork
      rand_run(0);
      rand_run(1);
    join
    repeat (20) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
